frame_overlay_gen: RTL and testbench
====================================

Name: frame_overlay_gen

Overview:
Parametrised successor to the single-pixel border stage in the VGA pixel pipeline. It sits between the last drawing stage and the VGA output register. It forces black in blanking and overlays a border of configurable thickness and colour, with an optional frame-counted blink. All timing signals are delayed by a configurable pipeline depth, so sync, counters and rgb stay aligned.

Parameters:
CNT_W, 11, width of hcount/vcount
RGB_W, 12, pixel colour width
H_ACTIVE, 1024, visible pixels per line
V_ACTIVE, 768, visible lines per frame
BORDER_W, 1, border thickness in pixels (1..H_ACTIVE/2)
BORDER_RGB, 12'h0F0, border colour
PIPE_DEPTH, 1, output latency in clocks (>=1)
BLINK_FRAMES, 30, frames per blink half-period (>=1)
GRID_STEP, 64, grid pitch in pixels (optional feature only; power of two)

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous reset, active-low
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
hblank  in  1  horizontal blank
vblank  in  1  vertical blank
hcount  in  CNT_W  pixel x
vcount  in  CNT_W  pixel y
rgb  in  RGB_W  upstream pixel
border_en  in  1  1 = draw border
blink_en  in  1  1 = border blinks
hsync_out, vsync_out, hblank_out, vblank_out  out  1  delayed copies
hcount_out, vcount_out  out  CNT_W  delayed copies
rgb_out  out  RGB_W  final pixel
blink_phase  out  1  current blink phase (1 = border hidden)

Behaviour:
- One clock; reset synchronous, active-low; all state updates on posedge clk.
- Reset: every output 0. Frame counter is 0, blink_phase is 0, vsync_prev is 1, and all pipeline stages are 0.
- Pixel selection, evaluated combinationally on stage-0 inputs, in priority order:
  1. hblank or vblank -> 0.
  2. border_hit and border_en and not (blink_en and blink_phase) -> BORDER_RGB.
  3. Otherwise rgb.
- border_hit = hcount < BORDER_W, or hcount >= H_ACTIVE-BORDER_W, or vcount < BORDER_W, or vcount >= V_ACTIVE-BORDER_W. All comparisons are unsigned at CNT_W.
- Latency: every output equals its input exactly PIPE_DEPTH clocks earlier. With PIPE_DEPTH=1 the block is cycle-identical to the previous generation at default parameters.
- Frame tick = vsync & ~vsync_prev, with vsync_prev registered each cycle.
- Blink FSM: two states, SHOW (blink_phase=0) and HIDE (blink_phase=1).
  - On each frame tick with blink_en=1, the counter increments. When it reaches BLINK_FRAMES-1 and another tick arrives, it wraps to 0 and the state toggles.
  - blink_en=0 clears the counter and forces SHOW on the next clock.
  - blink_phase changes only on frame-tick cycles or on blink_en fall, so the border is never torn mid-frame.
- border_en and blink_en are sampled per pixel. A mid-frame change affects pixels from the next clock onward.
- Reset asserted mid-frame clears the pipeline. Outputs are 0 for PIPE_DEPTH clocks after release, then track the inputs.
- Counter width is clog2(BLINK_FRAMES); BLINK_FRAMES=1 toggles every frame.

Optional Feature:
FRAME_OVERLAY_GRID_EN
- Defined: adds a priority level between steps 2 and 3. Pixels with hcount[log2(GRID_STEP)-1:0]==0 or vcount[log2(GRID_STEP)-1:0]==0 are drawn in BORDER_RGB when border_en=1. Grid pixels blink together with the border.
- Undefined: no grid logic; behaviour is exactly as above.

Decomposition:
- Package frame_overlay_pkg holds:
  - the RGB_BLACK constant
  - the default BORDER_RGB
  - the blink state enum (SHOW, HIDE)
  - a clog2 helper function
- Sub-module pipe_delay (params WIDTH, DEPTH; synchronous active-low clear). It carries the concatenated {syncs, blanks, counts, rgb} bus. The top level holds selection logic, edge detect and the blink FSM.

Test Plan:
- Defaults, border_en=1, blink_en=0, rgb=12'hABC; sweep hcount 0..1023 on vcount=100 -> rgb_out=12'h0F0 at hcount 0 and 1023, 12'hABC elsewhere, with 1-clock latency.
- BORDER_W=4, PIPE_DEPTH=3 -> border on hcount 0..3 and 1020..1023; every output lags its input by exactly 3 clocks.
- hblank=1 with hcount=0 and border_en=1 -> rgb_out=0; vblank=1 on vcount=767 -> rgb_out=0.
- blink_en=1, BLINK_FRAMES=2, 6 vsync rising edges -> blink_phase sequence 0,0,1,1,0,0; border pixel outputs rgb while blink_phase=1.
- blink_en dropped while blink_phase=1 -> blink_phase=0 on next clock; counter restarts at 0.
- rst_n low for 2 clocks mid-line -> all outputs 0 during reset and for PIPE_DEPTH clocks after; no spurious frame tick if vsync is high at release.

Source files
------------

// File: rtl/frame_overlay_pkg.sv
// frame_overlay_pkg: shared constants, types and helpers for frame_overlay_gen.
//   RGB_BLACK       - colour forced during blanking
//   BORDER_RGB_DEF  - default border colour
//   blink_state_t   - blink FSM states (SHOW = border visible, HIDE = hidden)
//   clog2()         - ceiling log2, usable in constant expressions
package frame_overlay_pkg;

  localparam logic [11:0] RGB_BLACK      = 12'h000;
  localparam logic [11:0] BORDER_RGB_DEF = 12'h0F0;

  typedef enum logic {
    SHOW = 1'b0,
    HIDE = 1'b1
  } blink_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< result) < value) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_overlay_gen_pipe_delay.sv
// pipe_delay: DEPTH-stage register delay line for a WIDTH-bit bus.
//   clk   - clock
//   rst_n - synchronous active-low clear of every stage
//   din   - bus entering the delay line
//   dout  - din delayed by exactly DEPTH clocks
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift register: stage 0 captures din, later stages follow; clear zeroes all
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/frame_overlay_gen.sv
// frame_overlay_gen: final pixel stage of the VGA pipeline. Blacks out blanking,
// overlays a border of BORDER_W pixels in BORDER_RGB, optionally blinking it
// every BLINK_FRAMES frames, and delays all timing signals by PIPE_DEPTH clocks.
//
// Optional build macro: FRAME_OVERLAY_GRID_EN adds a grid every GRID_STEP pixels
// drawn in BORDER_RGB (below the border in priority, blinks with the border).
//
// Ports:
//   clk, rst_n                       - pixel clock, synchronous active-low reset
//   hsync, vsync, hblank, vblank     - raster timing in
//   hcount, vcount                   - pixel coordinates in (CNT_W)
//   rgb                              - upstream pixel (RGB_W)
//   border_en, blink_en              - border draw / blink enables (per pixel)
//   hsync_out .. vcount_out          - timing delayed by PIPE_DEPTH
//   rgb_out                          - final pixel delayed by PIPE_DEPTH
//   blink_phase                      - 1 while the border is hidden
module frame_overlay_gen
  import frame_overlay_pkg::*;
#(
  parameter int               CNT_W        = 11,
  parameter int               RGB_W        = 12,
  parameter int               H_ACTIVE     = 1024,
  parameter int               V_ACTIVE     = 768,
  parameter int               BORDER_W     = 1,
  parameter logic [RGB_W-1:0] BORDER_RGB   = RGB_W'(BORDER_RGB_DEF),
  parameter int               PIPE_DEPTH   = 1,
  parameter int               BLINK_FRAMES = 30,
  parameter int               GRID_STEP    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             hblank,
  input  logic             vblank,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic [RGB_W-1:0] rgb,
  input  logic             border_en,
  input  logic             blink_en,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             blink_phase
);

  // A 1-frame blink period still needs one counter bit to keep the logic uniform
  localparam int BLINK_W_RAW = clog2(BLINK_FRAMES);
  localparam int BLINK_W     = (BLINK_W_RAW < 1) ? 1 : BLINK_W_RAW;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [CNT_W-1:0] BORDER_LO = CNT_W'(BORDER_W);
  localparam logic [CNT_W-1:0] H_HI      = CNT_W'(H_ACTIVE - BORDER_W);
  localparam logic [CNT_W-1:0] V_HI      = CNT_W'(V_ACTIVE - BORDER_W);

  localparam int BUS_W = 4 + 2 * CNT_W + RGB_W;

  logic               vsync_prev_r;
  logic               frame_tick_s;
  blink_state_t       state_r;
  blink_state_t       state_s;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic [BLINK_W-1:0] blink_cnt_s;
  logic               border_hit_s;
  logic               border_vis_s;
  logic [RGB_W-1:0]   pix_sel_s;
  logic [BUS_W-1:0]   bus_in_s;
  logic [BUS_W-1:0]   bus_out_s;

`ifdef FRAME_OVERLAY_GRID_EN
  localparam logic [CNT_W-1:0] GRID_MASK = CNT_W'(GRID_STEP - 1);
  logic grid_hit_s;
`endif

  // vsync history for rising-edge detect; resets high so a vsync already high
  // at reset release is not mistaken for a new frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_prev_r <= 1'b1;
    end else begin
      vsync_prev_r <= vsync;
    end
  end

  assign frame_tick_s = vsync & ~vsync_prev_r;

  // Blink FSM state register and frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= SHOW;
      blink_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      blink_cnt_r <= blink_cnt_s;
    end
  end

  // Blink FSM next state: phase only moves on frame ticks, or returns to SHOW
  // when blinking is disabled, so a frame is never torn
  always_comb begin
    state_s     = state_r;
    blink_cnt_s = blink_cnt_r;
    if (!blink_en) begin
      state_s     = SHOW;
      blink_cnt_s = '0;
    end else if (frame_tick_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_s = '0;
        case (state_r)
          SHOW:    state_s = HIDE;
          HIDE:    state_s = SHOW;
          default: state_s = SHOW;
        endcase
      end else begin
        blink_cnt_s = blink_cnt_r + BLINK_W'(1);
      end
    end else begin
      state_s     = state_r;
      blink_cnt_s = blink_cnt_r;
    end
  end

  // Blink FSM output
  always_comb begin
    blink_phase = (state_r == HIDE);
  end

`ifdef FRAME_OVERLAY_GRID_EN
  // Grid lines fall where the low log2(GRID_STEP) coordinate bits are zero
  always_comb begin
    grid_hit_s = ((hcount & GRID_MASK) == '0) || ((vcount & GRID_MASK) == '0);
  end
`endif

  // Pixel selection on the un-delayed inputs, highest priority first
  always_comb begin
    border_hit_s = (hcount < BORDER_LO) || (hcount >= H_HI) ||
                   (vcount < BORDER_LO) || (vcount >= V_HI);
    border_vis_s = border_en && !(blink_en && (state_r == HIDE));
    if (hblank || vblank) begin
      pix_sel_s = RGB_W'(RGB_BLACK);
    end else if (border_hit_s && border_vis_s) begin
      pix_sel_s = BORDER_RGB;
`ifdef FRAME_OVERLAY_GRID_EN
    end else if (grid_hit_s && border_vis_s) begin
      pix_sel_s = BORDER_RGB;
`endif
    end else begin
      pix_sel_s = rgb;
    end
  end

  assign bus_in_s = {hsync, vsync, hblank, vblank, hcount, vcount, pix_sel_s};

  pipe_delay #(
    .WIDTH (BUS_W),
    .DEPTH (PIPE_DEPTH)
  ) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus_in_s),
    .dout  (bus_out_s)
  );

  assign {hsync_out, vsync_out, hblank_out, vblank_out,
          hcount_out, vcount_out, rgb_out} = bus_out_s;

endmodule

// File: tb/tb_frame_overlay_gen.sv
// tb_frame_overlay_gen: self-checking bench for frame_overlay_gen with
// BORDER_W=4, PIPE_DEPTH=3, BLINK_FRAMES=2. A frame-level reference model
// (expected pixel per input, a queue-like delay array, a frame/phase counter)
// is checked against every output on every cycle, plus literal expectations.
module tb_frame_overlay_gen;

  localparam int CNT_W = 11;
  localparam int RGB_W = 12;
  localparam int H_ACT = 1024;
  localparam int V_ACT = 768;
  localparam int BW    = 4;
  localparam int PD    = 3;
  localparam int BF    = 2;
  localparam logic [RGB_W-1:0] BRGB = 12'h0F0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             hsync, vsync, hblank, vblank;
  logic [CNT_W-1:0] hcount, vcount;
  logic [RGB_W-1:0] rgb;
  logic             border_en, blink_en;
  logic             hsync_out, vsync_out, hblank_out, vblank_out;
  logic [CNT_W-1:0] hcount_out, vcount_out;
  logic [RGB_W-1:0] rgb_out;
  logic             blink_phase;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             hs, vs, hb, vb;
    logic [CNT_W-1:0] hc, vc;
    logic [RGB_W-1:0] px;
  } rec_t;

  rec_t q [PD];
  bit   m_phase;
  int   m_frames;
  bit   m_vs_prev;

  frame_overlay_gen #(
    .CNT_W(CNT_W), .RGB_W(RGB_W), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
    .BORDER_W(BW), .BORDER_RGB(BRGB), .PIPE_DEPTH(PD), .BLINK_FRAMES(BF),
    .GRID_STEP(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .hblank(hblank),
    .vblank(vblank), .hcount(hcount), .vcount(vcount), .rgb(rgb),
    .border_en(border_en), .blink_en(blink_en), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblank_out(hblank_out), .vblank_out(vblank_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .rgb_out(rgb_out),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pixel straight from the selection rules
  function automatic logic [RGB_W-1:0] exp_pixel();
    int  hc, vc;
    bit  hit;
    hc  = int'(hcount);
    vc  = int'(vcount);
    hit = (hc < BW) || (hc >= H_ACT - BW) || (vc < BW) || (vc >= V_ACT - BW);
    if (hblank || vblank) return 12'h000;
    if (hit && border_en && !(blink_en && m_phase)) return BRGB;
    return rgb;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge
  task automatic model_edge();
    bit tick;
    if (!rst_n) begin
      for (int i = 0; i < PD; i++) q[i] = '{default: '0};
      m_phase   = 1'b0;
      m_frames  = 0;
      m_vs_prev = 1'b1;
    end else begin
      for (int i = PD - 1; i > 0; i--) q[i] = q[i-1];
      q[0] = '{hs: hsync, vs: vsync, hb: hblank, vb: vblank,
               hc: hcount, vc: vcount, px: exp_pixel()};
      tick = vsync && !m_vs_prev;
      m_vs_prev = vsync;
      if (!blink_en) begin
        m_frames = 0;
        m_phase  = 1'b0;
      end else if (tick) begin
        m_frames = m_frames + 1;
        if (m_frames == BF) begin
          m_frames = 0;
          m_phase  = !m_phase;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("hsync_out",   32'(hsync_out),   32'(q[PD-1].hs));
    chk("vsync_out",   32'(vsync_out),   32'(q[PD-1].vs));
    chk("hblank_out",  32'(hblank_out),  32'(q[PD-1].hb));
    chk("vblank_out",  32'(vblank_out),  32'(q[PD-1].vb));
    chk("hcount_out",  32'(hcount_out),  32'(q[PD-1].hc));
    chk("vcount_out",  32'(vcount_out),  32'(q[PD-1].vc));
    chk("rgb_out",     32'(rgb_out),     32'(q[PD-1].px));
    chk("blink_phase", 32'(blink_phase), 32'(m_phase));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_pix(input int hc, input int vc, input bit hb, input bit vb);
    hcount = CNT_W'(hc);
    vcount = CNT_W'(vc);
    hblank = hb;
    vblank = vb;
  endtask

  int          lit_hc [12] = '{0, 3, 4, 1019, 1020, 1023, 500, 500, 500, 500, 0, 10};
  int          lit_vc [12] = '{100, 100, 100, 100, 100, 100, 3, 4, 764, 763, 100, 767};
  bit          lit_hb [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  bit          lit_vb [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic [11:0] lit_px [12] = '{12'h0F0, 12'h0F0, 12'hABC, 12'hABC, 12'h0F0, 12'h0F0,
                               12'h0F0, 12'hABC, 12'h0F0, 12'hABC, 12'h000, 12'h000};
  logic [5:0]  blink_seq = 6'b001100;

  initial begin
    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; hblank = 1'b0; vblank = 1'b0;
    hcount = '0; vcount = '0; rgb = 12'hABC; border_en = 1'b1; blink_en = 1'b0;
    run(2);
    chk("reset_rgb_out", 32'(rgb_out), 32'h0);
    chk("reset_blink_phase", 32'(blink_phase), 32'h0);
    rst_n = 1'b1;

    // Border / blanking geometry with literal expectations
    for (int k = 0; k < 12; k++) begin
      set_pix(lit_hc[k], lit_vc[k], lit_hb[k], lit_vb[k]);
      run(PD);
      chk("geom_rgb_out", 32'(rgb_out), 32'(lit_px[k]));
    end

    // Latency: output holds the old pixel for PD-1 clocks, then changes
    set_pix(4, 100, 1'b0, 1'b0);
    run(PD);
    set_pix(0, 100, 1'b0, 1'b0);
    run(PD - 1);
    chk("latency_old", 32'(rgb_out), 32'hABC);
    run(1);
    chk("latency_new", 32'(rgb_out), 32'h0F0);

    // Blink: phase per frame is 0,0,1,1,0,0 with BLINK_FRAMES=2
    blink_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vsync = 1'b0;
      run(PD + 1);
      chk("blink_seq_phase", 32'(blink_phase), 32'(blink_seq[k]));
      chk("blink_seq_rgb", 32'(rgb_out), blink_seq[k] ? 32'hABC : 32'h0F0);
      vsync = 1'b1;
      step();
    end
    vsync = 1'b0;
    step();
    chk("blink_before_drop", 32'(blink_phase), 32'h1);
    blink_en = 1'b0;
    step();
    chk("blink_drop", 32'(blink_phase), 32'h0);
    blink_en = 1'b1;
    vsync = 1'b1; step(); vsync = 1'b0; step();
    chk("blink_restart_1", 32'(blink_phase), 32'h0);
    vsync = 1'b1; step(); vsync = 1'b0; step();
    chk("blink_restart_2", 32'(blink_phase), 32'h1);

    // Mid-line reset with vsync high at release
    set_pix(500, 300, 1'b0, 1'b0);
    rgb = 12'h123;
    vsync = 1'b1;
    rst_n = 1'b0;
    run(2);
    chk("rst_mid_rgb", 32'(rgb_out), 32'h0);
    chk("rst_mid_phase", 32'(blink_phase), 32'h0);
    rst_n = 1'b1;
    run(PD - 1);
    chk("rst_release_zero", 32'(rgb_out), 32'h0);
    chk("rst_release_hcount", 32'(hcount_out), 32'h0);
    run(1);
    chk("rst_release_track", 32'(rgb_out), 32'h123);
    vsync = 1'b0; step(); vsync = 1'b1; step();
    vsync = 1'b0; step();
    chk("no_spurious_tick", 32'(blink_phase), 32'h0);
    vsync = 1'b1; step();
    chk("second_tick_toggle", 32'(blink_phase), 32'h1);

    // Randomized traffic biased toward the border and blanking edges
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0:       hcount = CNT_W'($urandom_range(0, 7));
        1:       hcount = CNT_W'($urandom_range(1016, 1023));
        2:       hcount = CNT_W'($urandom_range(0, 2047));
        default: hcount = CNT_W'($urandom_range(8, 1015));
      endcase
      case ($urandom_range(0, 3))
        0:       vcount = CNT_W'($urandom_range(0, 7));
        1:       vcount = CNT_W'($urandom_range(760, 767));
        2:       vcount = CNT_W'($urandom_range(0, 2047));
        default: vcount = CNT_W'($urandom_range(8, 759));
      endcase
      rgb    = RGB_W'($urandom);
      hsync  = 1'($urandom_range(0, 1));
      hblank = ($urandom_range(0, 5) == 0);
      vblank = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0)  vsync = ~vsync;
      if ($urandom_range(0, 23) == 0) border_en = ~border_en;
      if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
